// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// holding each access for MEM_LAT wait cycles and returning a one-cycle ready.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output arb_state_t        dbg_state_o
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $fatal(1, "mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  // Handshake: a requester raises req with stable address/data and holds it
  // until its ready pulses for one cycle; req seen during that ready cycle is
  // ignored, so a held req cannot re-trigger the access that just completed.

  arb_state_t        state_q;
  logic [3:0]        cnt_q;
  logic              last_was_data_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ready_q, dm_ready_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic busy, done, decide, if_cand, dm_cand, grant_d, grant_i;

  always_comb begin
    busy    = (state_q != IDLE);
    done    = busy && (cnt_q == 4'd0);
    decide  = !busy || done;
    // The side being completed is still holding req for the old access.
    if_cand = if_req & ~if_ready_q & (state_q != BUSY_I);
    dm_cand = dm_req & ~dm_ready_q & (state_q != BUSY_D);
    grant_d = decide & dm_cand & (~if_cand | ~last_was_data_q);
    grant_i = decide & if_cand & ~grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      last_was_data_q <= 1'b0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_ready_q      <= 1'b0;
      dm_ready_q      <= 1'b0;
      if_rdata_q      <= '0;
      dm_rdata_q      <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if (done) begin
        if (state_q == BUSY_I) begin
          if_ready_q <= 1'b1;
          if_rdata_q <= mem_rdata;
        end else begin
          dm_ready_q <= 1'b1;
          if (!mem_we_q) dm_rdata_q <= mem_rdata;
        end
      end
      if (grant_d || grant_i) begin
        state_q         <= grant_d ? BUSY_D : BUSY_I;
        mem_en_q        <= 1'b1;
        mem_we_q        <= grant_d & dm_we;
        mem_addr_q      <= grant_d ? dm_addr : if_addr;
        mem_wdata_q     <= grant_d ? dm_wdata : '0;
        cnt_q           <= 4'(MEM_LAT - 1);
        last_was_data_q <= grant_d;
      end else if (done) begin
        state_q  <= IDLE;
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end else if (busy) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ready    = if_ready_q;
  assign dm_rdata    = dm_rdata_q;
  assign dm_ready    = dm_ready_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign stall_f     = if_req & ~if_ready_q;
  assign stall_m     = dm_req & ~dm_ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk, rst_n;
  int   n_cmp, n_fail;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;
  arb_state_t  st;

  logic        if1_req;
  logic [31:0] if1_addr, if1_rdata, dm1_rdata, mem1_addr, mem1_wdata, mem1_rdata;
  logic        if1_ready, dm1_ready, mem1_en, mem1_we, stall1_f, stall1_m;
  arb_state_t  st1;
  logic        zero_b;
  logic [31:0] zero_w;

  logic [31:0] mem_arr [0:63];

  assign zero_b     = 1'b0;
  assign zero_w     = 32'h0;
  assign mem_rdata  = mem_en  ? mem_arr[mem_addr[7:2]]  : 32'h0;
  assign mem1_rdata = mem1_en ? mem_arr[mem1_addr[7:2]] : 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m), .dbg_state_o(st)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ready(if1_ready),
    .dm_req(zero_b), .dm_we(zero_b), .dm_addr(zero_w), .dm_wdata(zero_w),
    .dm_rdata(dm1_rdata), .dm_ready(dm1_ready),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata), .stall_f(stall1_f), .stall_m(stall1_m), .dbg_state_o(st1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_arr[0]  = 32'hA000_0000;
    mem_arr[1]  = 32'hA000_0004;
    mem_arr[2]  = 32'hA000_0008;
    mem_arr[4]  = 32'hE3A0_1005;
    mem_arr[5]  = 32'hE281_1001;
    mem_arr[6]  = 32'hE282_2002;
    mem_arr[8]  = 32'h1111_2222;
    mem_arr[9]  = 32'h3333_4444;
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if1_req = 0; if1_addr = 0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_dm_ready", 64'(dm_ready), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_dm_rdata", 64'(dm_rdata), 64'd0);
    chk("rst_state", 64'(st), 64'(IDLE));

    // Single fetch, cycle 0..4
    tick(); rst_n = 1'b1; if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("f_c0_stall_f", 64'(stall_f), 64'd1);
    chk("f_c0_mem_en", 64'(mem_en), 64'd0);
    tick(); @(negedge clk);
    chk("f_c1_mem_en", 64'(mem_en), 64'd1);
    chk("f_c1_mem_addr", 64'(mem_addr), 64'h10);
    chk("f_c1_mem_we", 64'(mem_we), 64'd0);
    chk("f_c1_stall_f", 64'(stall_f), 64'd1);
    tick(); @(negedge clk);
    chk("f_c2_if_ready", 64'(if_ready), 64'd0);
    chk("f_c2_state", 64'(st), 64'(BUSY_I));
    chk("f_c2_stall_f", 64'(stall_f), 64'd1);
    tick(); @(negedge clk);
    chk("f_c3_if_ready", 64'(if_ready), 64'd1);
    chk("f_c3_if_rdata", 64'(if_rdata), 64'hE3A0_1005);
    chk("f_c3_stall_f", 64'(stall_f), 64'd0);
    chk("f_c3_mem_en", 64'(mem_en), 64'd0);

    // Store, started as the fetch requester drops its req
    tick(); if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("s_c0_if_ready", 64'(if_ready), 64'd0);
    chk("s_c0_if_rdata_hold", 64'(if_rdata), 64'hE3A0_1005);
    chk("s_c0_stall_m", 64'(stall_m), 64'd1);
    chk("s_c0_mem_en", 64'(mem_en), 64'd0);
    tick(); @(negedge clk);
    chk("s_c1_mem_we", 64'(mem_we), 64'd1);
    chk("s_c1_mem_addr", 64'(mem_addr), 64'h40);
    chk("s_c1_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    tick(); @(negedge clk);
    chk("s_c2_mem_we", 64'(mem_we), 64'd1);
    chk("s_c2_mem_addr", 64'(mem_addr), 64'h40);
    chk("s_c2_dm_ready", 64'(dm_ready), 64'd0);
    tick(); @(negedge clk);
    chk("s_c3_dm_ready", 64'(dm_ready), 64'd1);
    chk("s_c3_dm_rdata", 64'(dm_rdata), 64'd0);
    chk("s_c3_mem_we", 64'(mem_we), 64'd0);
    chk("s_c3_stall_m", 64'(stall_m), 64'd0);
    tick(); dm_req = 0; dm_we = 0;
    @(negedge clk);
    chk("s_c4_dm_ready", 64'(dm_ready), 64'd0);

    // Simultaneous from reset: data first, fetch back-to-back
    rst_n = 1'b0;
    @(negedge clk);
    chk("sim_rst_state", 64'(st), 64'(IDLE));
    tick(); rst_n = 1'b1;
    if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    tick(); @(negedge clk);
    chk("sim_c1_state", 64'(st), 64'(BUSY_D));
    chk("sim_c1_mem_addr", 64'(mem_addr), 64'h20);
    chk("sim_c1_mem_en", 64'(mem_en), 64'd1);
    tick(); @(negedge clk);
    chk("sim_c2_mem_en", 64'(mem_en), 64'd1);
    tick(); @(negedge clk);
    chk("sim_c3_dm_ready", 64'(dm_ready), 64'd1);
    chk("sim_c3_dm_rdata", 64'(dm_rdata), 64'h1111_2222);
    chk("sim_c3_mem_en", 64'(mem_en), 64'd1);
    chk("sim_c3_mem_addr", 64'(mem_addr), 64'h14);
    chk("sim_c3_state", 64'(st), 64'(BUSY_I));
    tick(); dm_req = 0;
    @(negedge clk);
    chk("sim_c4_mem_en", 64'(mem_en), 64'd1);
    chk("sim_c4_if_ready", 64'(if_ready), 64'd0);
    tick(); @(negedge clk);
    chk("sim_c5_if_ready", 64'(if_ready), 64'd1);
    chk("sim_c5_if_rdata", 64'(if_rdata), 64'hE281_1001);
    chk("sim_c5_mem_en", 64'(mem_en), 64'd0);
    tick(); if_req = 0;
    @(negedge clk);
    chk("sim_c6_state", 64'(st), 64'(IDLE));

    // Fairness: both held, last grant was fetch -> D, I, D, I
    tick(); if_req = 1; if_addr = 32'h18; dm_req = 1; dm_we = 0; dm_addr = 32'h24;
    tick(); @(negedge clk);
    chk("fair_c1_state", 64'(st), 64'(BUSY_D));
    tick(); tick(); @(negedge clk);
    chk("fair_c3_state", 64'(st), 64'(BUSY_I));
    chk("fair_c3_dm_ready", 64'(dm_ready), 64'd1);
    chk("fair_c3_dm_rdata", 64'(dm_rdata), 64'h3333_4444);
    tick(); tick(); @(negedge clk);
    chk("fair_c5_state", 64'(st), 64'(BUSY_D));
    chk("fair_c5_if_ready", 64'(if_ready), 64'd1);
    chk("fair_c5_if_rdata", 64'(if_rdata), 64'hE282_2002);
    tick(); tick(); @(negedge clk);
    chk("fair_c7_state", 64'(st), 64'(BUSY_I));
    chk("fair_c7_dm_ready", 64'(dm_ready), 64'd1);
    // Both requesters flushed during the last fetch; its ready still pulses
    tick(); if_req = 0; dm_req = 0;
    @(negedge clk);
    chk("flush_c8_mem_en", 64'(mem_en), 64'd1);
    tick(); @(negedge clk);
    chk("flush_c9_if_ready", 64'(if_ready), 64'd1);
    chk("flush_c9_mem_en", 64'(mem_en), 64'd0);
    chk("flush_c9_state", 64'(st), 64'(IDLE));

    // Reset in the middle of a fetch
    tick(); if_req = 1; if_addr = 32'h10;
    tick(); @(negedge clk);
    chk("rmid_c1_mem_en", 64'(mem_en), 64'd1);
    tick(); rst_n = 1'b0;
    @(negedge clk);
    chk("rmid_mem_en", 64'(mem_en), 64'd0);
    chk("rmid_if_ready", 64'(if_ready), 64'd0);
    chk("rmid_if_rdata", 64'(if_rdata), 64'd0);
    chk("rmid_state", 64'(st), 64'(IDLE));
    tick(); rst_n = 1'b1;
    tick(); @(negedge clk);
    chk("rmid_r1_mem_en", 64'(mem_en), 64'd1);
    tick(); @(negedge clk);
    chk("rmid_r2_if_ready", 64'(if_ready), 64'd0);
    tick(); @(negedge clk);
    chk("rmid_r3_if_ready", 64'(if_ready), 64'd1);
    chk("rmid_r3_if_rdata", 64'(if_rdata), 64'hE3A0_1005);
    tick(); if_req = 0;

    // MEM_LAT=1: fetches at 0x0, 0x4, 0x8; ready at cycles 2, 5, 8
    for (int k = 0; k < 3; k++) begin
      tick(); if1_req = 1; if1_addr = 32'(k * 4);
      @(negedge clk);
      chk("l1_c0_mem_en", 64'(mem1_en), 64'd0);
      tick(); @(negedge clk);
      chk("l1_c1_mem_en", 64'(mem1_en), 64'd1);
      chk("l1_c1_mem_addr", 64'(mem1_addr), 64'(k * 4));
      chk("l1_c1_ready", 64'(if1_ready), 64'd0);
      tick(); @(negedge clk);
      chk("l1_c2_ready", 64'(if1_ready), 64'd1);
      chk("l1_c2_rdata", 64'(if1_rdata), 64'(32'hA000_0000 + 32'(k * 4)));
      chk("l1_c2_mem_en", 64'(mem1_en), 64'd0);
    end
    tick(); if1_req = 0;
    @(negedge clk);
    chk("l1_end_ready", 64'(if1_ready), 64'd0);
    chk("l1_end_state", 64'(st1), 64'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
